// File: rtl/mem_xbar_pkg.sv
// Shared types and helpers for the mem_xbar request/response crossbar.
// The response tag travels with every granted access until its response is delivered.
package mem_xbar_pkg;

    localparam int MAX_MASTERS    = 8;
    localparam int MAX_SLAVES     = 8;
    localparam int MAX_ADDR_WIDTH = 64;
    localparam int SLV_IDW        = $clog2(MAX_SLAVES);

    typedef struct packed {
        logic               valid;
        logic [SLV_IDW-1:0] slv;
        logic               is_read;
        logic               err;
    } rsp_tag_t;

    function automatic logic addr_hit(input logic [MAX_ADDR_WIDTH-1:0] addr,
                                      input logic [MAX_ADDR_WIDTH-1:0] base,
                                      input logic [MAX_ADDR_WIDTH-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/mem_xbar_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req, search starts at the pointer,
// pointer moves to winner+1 after a grant and holds while idle.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        gnt_o = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[(int'(ptr_q) + i) % N]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + i) % N);
            end
        end
        if (found) gnt_o[win] = 1'b1;
        ptr_d = ptr_q;
        if (found) ptr_d = (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_xbar.sv
// NUM_MASTERS x NUM_SLAVES BRAM-style crossbar with base/mask decode and per-slave round robin.
// Optional macro MEM_XBAR_DECERR_EN: unmapped accesses answer with m_err_o instead of hitting the last slave.
module mem_xbar
    import mem_xbar_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int RD_LATENCY  = 1,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    output logic [NUM_MASTERS-1:0]            m_rvalid_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_SLAVES-1:0]             s_en_o,
    output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] s_we_o,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]  s_addr_o,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_wdata_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata_i
);

    localparam int BE = DATA_WIDTH / 8;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    // Handshake: m_req_i is a valid that holds with stable we/addr/wdata until m_gnt_o;
    // the access transfers in the cycle both are high, and exactly one m_rvalid_o
    // pulse follows RD_LATENCY cycles later. Masters have no backpressure on responses.

    logic [NUM_MASTERS-1:0] mapped;
    logic [SLV_IDW-1:0]     tgt     [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] route;
    logic [NUM_MASTERS-1:0] dec_err;
    logic [NUM_MASTERS-1:0] slv_req [NUM_SLAVES];
    logic [NUM_MASTERS-1:0] slv_gnt [NUM_SLAVES];
    rsp_tag_t               tag_in  [NUM_MASTERS];
    rsp_tag_t               pipe    [NUM_MASTERS][RD_LATENCY];

    // Descending scan so the lowest-index matching slave is the one left standing.
    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            mapped[m] = 1'b0;
            tgt[m]    = SLV_IDW'(NUM_SLAVES - 1);
            for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
                if (addr_hit(MAX_ADDR_WIDTH'(m_addr_i[m*AW +: AW]),
                             MAX_ADDR_WIDTH'(SLV_BASE[s*AW +: AW]),
                             MAX_ADDR_WIDTH'(SLV_MASK[s*AW +: AW]))) begin
                    mapped[m] = 1'b1;
                    tgt[m]    = SLV_IDW'(s);
                end
            end
        end
    end

`ifdef MEM_XBAR_DECERR_EN
    assign route   = m_req_i & mapped;
    assign dec_err = rst_i ? '0 : (m_req_i & ~mapped);
`else
    assign route   = m_req_i;
    assign dec_err = '0;
`endif

    always_comb begin
        for (int s = 0; s < NUM_SLAVES; s++) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                slv_req[s][m] = route[m] && !rst_i && (tgt[m] == SLV_IDW'(s));
            end
        end
    end

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_arb
        rr_arbiter #(.N(NUM_MASTERS)) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (slv_req[s]),
            .gnt_o (slv_gnt[s])
        );
    end

    always_comb begin
        m_gnt_o = dec_err;
        for (int s = 0; s < NUM_SLAVES; s++) m_gnt_o = m_gnt_o | slv_gnt[s];
    end

    always_comb begin
        s_en_o    = '0;
        s_we_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            s_en_o[s] = |slv_gnt[s];
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (slv_gnt[s][m]) begin
                    s_we_o[s*BE +: BE]    = m_we_i[m*BE +: BE];
                    s_addr_o[s*AW +: AW]  = m_addr_i[m*AW +: AW];
                    s_wdata_o[s*DW +: DW] = m_wdata_i[m*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            tag_in[m] = '0;
            if (m_gnt_o[m]) begin
                tag_in[m].valid   = 1'b1;
                tag_in[m].slv     = tgt[m];
                tag_in[m].is_read = ~|m_we_i[m*BE +: BE];
                tag_in[m].err     = dec_err[m];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int m = 0; m < NUM_MASTERS; m++)
                for (int k = 0; k < RD_LATENCY; k++) pipe[m][k] <= '0;
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                pipe[m][0] <= tag_in[m];
                for (int k = 1; k < RD_LATENCY; k++) pipe[m][k] <= pipe[m][k-1];
            end
        end
    end

    // The tagged slave's read port is sampled as the response leaves the pipeline.
    always_comb begin
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (!rst_i && pipe[m][RD_LATENCY-1].valid) begin
                m_rvalid_o[m] = 1'b1;
`ifdef MEM_XBAR_DECERR_EN
                m_err_o[m]    = pipe[m][RD_LATENCY-1].err;
`endif
                if (pipe[m][RD_LATENCY-1].is_read && !pipe[m][RD_LATENCY-1].err) begin
                    for (int s = 0; s < NUM_SLAVES; s++) begin
                        if (pipe[m][RD_LATENCY-1].slv == SLV_IDW'(s))
                            m_rdata_o[m*DW +: DW] = s_rdata_i[s*DW +: DW];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_xbar.sv
// Randomised scoreboard bench for mem_xbar: 2 masters, 2 overlapping slave windows, RD_LATENCY=2.
// Builds for both settings of MEM_XBAR_DECERR_EN.
module tb_mem_xbar;

    localparam int NM  = 2;
    localparam int NS  = 2;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int BE  = DW / 8;
    localparam int LAT = 2;
    localparam int TW  = BE + AW + DW;
    localparam int EW  = 32 + 1 + DW;
    localparam int PW  = 1 + BE + AW + DW;
    // Slave 0 is a window inside slave 1's range, so it must win where they overlap.
    localparam logic [NS*AW-1:0] BASE = {32'h4000_0000, 32'h4000_8000};
    localparam logic [NS*AW-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_8000};

    logic             clk;
    logic             rst;
    logic [NM-1:0]    m_req;
    logic [NM*BE-1:0] m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_gnt;
    logic [NM-1:0]    m_rvalid;
    logic [NM*DW-1:0] m_rdata;
    logic [NM-1:0]    m_err;
    logic [NS-1:0]    s_en;
    logic [NS*BE-1:0] s_we;
    logic [NS*AW-1:0] s_addr;
    logic [NS*DW-1:0] s_wdata;
    logic [NS*DW-1:0] s_rdata;

    mem_xbar #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .RD_LATENCY  (LAT),
        .SLV_BASE    (BASE),
        .SLV_MASK    (MASK)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_req_i    (m_req),
        .m_we_i     (m_we),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_gnt_o    (m_gnt),
        .m_rvalid_o (m_rvalid),
        .m_rdata_o  (m_rdata),
        .m_err_o    (m_err),
        .s_en_o     (s_en),
        .s_we_o     (s_we),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_rdata_i  (s_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] base_a [NS];
    logic [AW-1:0] mask_a [NS];

    // ---------------- reference model ----------------
    logic [TW-1:0] stim_q [NM][$];
    logic [EW-1:0] exp_q  [NM][$];
    logic [TW-1:0] cur    [NM];
    logic [NM-1:0] active;
    int            rr_ptr [NS];
    logic          gap_en;

    function automatic int ref_decode(input logic [AW-1:0] a);
        for (int s = 0; s < NS; s++)
            if ((a & mask_a[s]) == base_a[s]) return s;
`ifdef MEM_XBAR_DECERR_EN
        return -1;
`else
        return NS - 1;
`endif
    endfunction

    function automatic logic [DW-1:0] slave_data(input int s, input logic [AW-1:0] a);
        return {a, 32'hC0DE_0000 + 32'(s)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave memories: read data is a pure function of slave id and address, delayed LAT cycles.
    logic [DW-1:0] spipe [NS][LAT];
    always @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            for (int k = LAT - 1; k > 0; k--) spipe[s][k] <= spipe[s][k-1];
            spipe[s][0] <= s_en[s] ? slave_data(s, s_addr[s*AW +: AW]) : 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end
    always_comb begin
        s_rdata = '0;
        for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = spipe[s][LAT-1];
    end

    // ---------------- driver ----------------
    task automatic run_cycle();
        int            tgt [NM];
        int            win [NS];
        int            mm;
        logic [NM-1:0] exp_gnt;
        logic [PW-1:0] exp_p;
        logic [PW-1:0] act_p;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          is_rd;
        for (int m = 0; m < NM; m++) begin
            if (!active[m] && stim_q[m].size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                cur[m]    = stim_q[m].pop_front();
                active[m] = 1'b1;
            end
            m_req[m]            = active[m];
            m_we[m*BE +: BE]    = active[m] ? cur[m][TW-1 -: BE] : '0;
            m_addr[m*AW +: AW]  = active[m] ? cur[m][AW+DW-1 -: AW] : '0;
            m_wdata[m*DW +: DW] = active[m] ? cur[m][DW-1:0] : '0;
        end
        @(negedge clk);
        exp_gnt = '0;
        for (int s = 0; s < NS; s++) win[s] = -1;
        for (int m = 0; m < NM; m++) tgt[m] = ref_decode(cur[m][AW+DW-1 -: AW]);
        if (!rst) begin
            for (int s = 0; s < NS; s++) begin
                for (int i = 0; i < NM; i++) begin
                    mm = (rr_ptr[s] + i) % NM;
                    if (win[s] < 0 && active[mm] && tgt[mm] == s) win[s] = mm;
                end
                if (win[s] >= 0) begin
                    exp_gnt[win[s]] = 1'b1;
                    rr_ptr[s] = (win[s] + 1) % NM;
                end
            end
            for (int m = 0; m < NM; m++)
                if (active[m] && tgt[m] < 0) exp_gnt[m] = 1'b1;
        end
        check("gnt", 128'(m_gnt), 128'(exp_gnt));
        for (int s = 0; s < NS; s++) begin
            exp_p = '0;
            if (win[s] >= 0) exp_p = {1'b1, cur[win[s]]};
            act_p = {s_en[s], s_we[s*BE +: BE], s_addr[s*AW +: AW], s_wdata[s*DW +: DW]};
            check($sformatf("s_port%0d", s), 128'(act_p), 128'(exp_p));
        end
        for (int m = 0; m < NM; m++) begin
            if (exp_gnt[m]) begin
                a     = cur[m][AW+DW-1 -: AW];
                is_rd = (cur[m][TW-1 -: BE] == '0);
                d     = (is_rd && tgt[m] >= 0) ? slave_data(tgt[m], a) : '0;
                exp_q[m].push_back({32'(cyc + LAT), tgt[m] < 0, d});
                active[m] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 3000 && (active != '0 || stim_q[0].size() > 0 || stim_q[1].size() > 0)) begin
            run_cycle();
            i++;
        end
        check("drain_bound", 128'(i < 3000), 128'(1));
        repeat (LAT + 2) run_cycle();
        for (int m = 0; m < NM; m++)
            check($sformatf("rsp_outstanding_m%0d", m), 128'(exp_q[m].size()), 128'(0));
    endtask

    task automatic push_txn(input int m, input logic [BE-1:0] we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
        stim_q[m].push_back({we, a, wd});
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        for (int m = 0; m < NM; m++) exp_q[m].delete();
        for (int s = 0; s < NS; s++) rr_ptr[s] = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] ent;
        if (rst) begin
            check("reset_outputs", 128'({m_rvalid, m_err, m_rdata}), 128'(0));
        end else begin
            for (int m = 0; m < NM; m++) begin
                if (m_rvalid[m]) begin
                    n_checks++;
                    if (exp_q[m].size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_spurious m%0d: got rvalid rdata=%0h, expected none (cycle %0d)",
                                 m, m_rdata[m*DW +: DW], cyc);
                    end else begin
                        ent = exp_q[m].pop_front();
                        check($sformatf("rsp_cycle_m%0d", m), 128'(cyc), 128'(ent[EW-1 -: 32]));
                        check($sformatf("rsp_err_m%0d", m), 128'(m_err[m]), 128'(ent[DW]));
                        check($sformatf("rsp_data_m%0d", m), 128'(m_rdata[m*DW +: DW]), 128'(ent[DW-1:0]));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] a;
        logic [BE-1:0] we;
        for (int s = 0; s < NS; s++) begin
            base_a[s] = BASE[s*AW +: AW];
            mask_a[s] = MASK[s*AW +: AW];
            rr_ptr[s] = 0;
        end
        rst     = 1'b1;
        gap_en  = 1'b0;
        active  = '0;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        for (int m = 0; m < NM; m++) cur[m] = '0;

        // Single read held through reset, granted on the first cycle out of it.
        push_txn(0, 8'h00, 32'h4000_0010, 64'h0);
        repeat (3) run_cycle();
        rst = 1'b0;
        drain();

        // Contention on slave 0 with continuous requests.
        for (int i = 0; i < 6; i++) begin
            push_txn(0, 8'h00, 32'h4000_8000 + 32'(i * 8), 64'h0);
            push_txn(1, 8'h00, 32'h4000_9000 + 32'(i * 8), 64'h0);
        end
        drain();

        // Parallel access to different slaves.
        push_txn(0, 8'h00, 32'h4000_8040, 64'h0);
        push_txn(1, 8'h00, 32'h4000_0040, 64'h0);
        drain();

        // Unmapped addresses, read and write.
        push_txn(0, 8'h00, 32'hF000_0000, 64'h0);
        push_txn(1, 8'hFF, 32'hF000_0008, 64'hAAAA_5555_AAAA_5555);
        drain();

        // Partial write.
        push_txn(1, 8'h0F, 32'h4000_8010, 64'h1122_3344_5566_7788);
        drain();

        // Random traffic with idle gaps.
        gap_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            for (int m = 0; m < NM; m++) begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h4000_8000 | ($urandom & 32'h0000_7FF8);
                    1:       a = 32'h4000_0000 | ($urandom & 32'h0000_7FF8);
                    2:       a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF8);
                    default: a = $urandom;
                endcase
                we = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                push_txn(m, we, a, {$urandom, $urandom});
            end
        end
        drain();

        // Reset with two reads in flight; pointer must come back at M0.
        gap_en = 1'b0;
        push_txn(0, 8'h00, 32'h4000_8100, 64'h0);
        push_txn(0, 8'h00, 32'h4000_8108, 64'h0);
        repeat (2) run_cycle();
        enter_reset();
        push_txn(0, 8'h00, 32'h4000_8200, 64'h0);
        push_txn(1, 8'h00, 32'h4000_8300, 64'h0);
        repeat (3) run_cycle();
        rst = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
